// File: rtl/sram_arbiter_if.sv
// CPU and video request/acknowledge bundle for sram_arbiter.
// master = requesters side, slave = arbiter side.
interface sram_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 21
);
   logic                  cpu_req;
   logic                  cpu_we;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [7:0]            cpu_wdata;
   logic                  cpu_ack;
   logic [7:0]            cpu_rdata;
   logic                  vid_req;
   logic [ADDR_WIDTH-1:0] vid_addr;
   logic                  vid_ack;
   logic [7:0]            vid_rdata;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr,
      input  cpu_ack, cpu_rdata, vid_ack, vid_rdata
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr,
      output cpu_ack, cpu_rdata, vid_ack, vid_rdata
   );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port (CPU r/w, video r/o) arbiter and sequencer for the external async 8-bit SRAM.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed video-over-CPU priority.
module sram_arbiter #(
   parameter int unsigned ADDR_WIDTH    = 21,
   parameter int unsigned ACCESS_CYCLES = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   sram_arbiter_if.slave         bus,
   output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
   inout  wire  [7:0]            SRAM_DATA,
   output logic                  SRAM_WE_n
);

   typedef enum logic [2:0] {IDLE, VID_RD, CPU_RD, CPU_WR, DONE} state_t;

   localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);
   localparam logic [3:0] WE_END   = 4'(ACCESS_CYCLES - 2);

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            wdata_q;
   logic                  drive_q;
   logic                  we_n_q;
   logic                  cpu_ack_q;
   logic                  vid_ack_q;
   logic [7:0]            cpu_rdata_q;
   logic [7:0]            vid_rdata_q;
   logic                  grant_vid;
   logic                  grant_cpu;
   logic                  last_cycle;

   assign last_cycle = (state_q inside {VID_RD, CPU_RD, CPU_WR}) && (cnt_q == LAST_CNT);

`ifdef SRAM_ARB_RR_EN
   typedef enum logic {PTR_VID, PTR_CPU} ptr_t;

   ptr_t ptr_q;

   // The pointer names the port that wins a tie; a lone request always wins.
   always_comb begin
      grant_vid = bus.vid_req && (!bus.cpu_req || (ptr_q == PTR_VID));
      grant_cpu = bus.cpu_req && !grant_vid;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr_q <= PTR_VID;
      end else if (last_cycle) begin
         ptr_q <= (state_q == VID_RD) ? PTR_CPU : PTR_VID;
      end
   end
`else
   always_comb begin
      grant_vid = bus.vid_req;
      grant_cpu = bus.cpu_req && !bus.vid_req;
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         drive_q     <= 1'b0;
         we_n_q      <= 1'b1;
         cpu_ack_q   <= 1'b0;
         vid_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         vid_rdata_q <= '0;
      end else begin
         cpu_ack_q <= 1'b0;
         vid_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (grant_vid) begin
                  state_q <= VID_RD;
                  addr_q  <= bus.vid_addr;
               end else if (grant_cpu) begin
                  state_q <= bus.cpu_we ? CPU_WR : CPU_RD;
                  addr_q  <= bus.cpu_addr;
                  drive_q <= bus.cpu_we;
                  if (bus.cpu_we) begin
                     wdata_q <= bus.cpu_wdata;
                  end
               end
            end
            VID_RD, CPU_RD, CPU_WR: begin
               if (cnt_q == LAST_CNT) begin
                  state_q <= DONE;
                  we_n_q  <= 1'b1;
                  drive_q <= 1'b0;
                  if (state_q == VID_RD) begin
                     vid_rdata_q <= SRAM_DATA;
                     vid_ack_q   <= 1'b1;
                  end else begin
                     if (state_q == CPU_RD) begin
                        cpu_rdata_q <= SRAM_DATA;
                     end
                     cpu_ack_q <= 1'b1;
                  end
               end else begin
                  cnt_q  <= cnt_q + 4'd1;
                  // Strobe for the coming cycle: low from the second access cycle up to, not including, the last.
                  we_n_q <= !((state_q == CPU_WR) && (cnt_q < WE_END));
               end
            end
            DONE: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign SRAM_ADDR     = addr_q;
   assign SRAM_WE_n     = we_n_q;
   assign SRAM_DATA     = drive_q ? wdata_q : 8'hzz;
   assign bus.cpu_ack   = cpu_ack_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.vid_ack   = vid_ack_q;
   assign bus.vid_rdata = vid_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus random requesters against a slot-level model.
// Follows SRAM_ARB_RR_EN the same way the design does.
module tb_sram_arbiter;

   localparam int AC = 3;
`ifdef SRAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [20:0] SRAM_ADDR;
   wire  [7:0]  SRAM_DATA;
   logic        SRAM_WE_n;
   logic        tb_oe = 1'b0;
   logic        tb_force = 1'b0;
   logic [7:0]  sram_drv = '0;

   sram_arbiter_if #(.ADDR_WIDTH(21)) bus ();

   sram_arbiter #(.ADDR_WIDTH(21), .ACCESS_CYCLES(AC)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .SRAM_ADDR (SRAM_ADDR),
      .SRAM_DATA (SRAM_DATA),
      .SRAM_WE_n (SRAM_WE_n)
   );

   always #5 clock = ~clock;

   assign SRAM_DATA = tb_oe ? sram_drv : 8'hzz;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   // Pin-level SRAM contents (written by the strobe) and the reference contents (written by the model).
   logic [7:0] phys    [logic [20:0]];
   logic [7:0] ref_mem [logic [20:0]];

   function automatic logic [7:0] init_byte(input logic [20:0] a);
      return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'hA5;
   endfunction

   function automatic logic [7:0] phys_rd(input logic [20:0] a);
      return phys.exists(a) ? phys[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] ref_rd(input logic [20:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
   endfunction

   always @(posedge SRAM_WE_n) begin
      if (!reset) phys[SRAM_ADDR] = SRAM_DATA;
   end

   // Model: a grant in cycle g occupies g+1..g+AC, acks in g+AC+1, next grant no earlier than g+AC+2.
   bit          m_busy;
   int          m_g;
   bit          m_port_cpu;
   bit          m_we;
   logic [20:0] m_addr;
   logic [7:0]  m_wdata;
   logic [20:0] m_last_addr;
   logic [7:0]  m_cpu_rd;
   logic [7:0]  m_vid_rd;
   bit          m_ptr_cpu;

   task automatic model_reset();
      m_busy      = 1'b0;
      m_last_addr = '0;
      m_cpu_rd    = '0;
      m_vid_rd    = '0;
      m_ptr_cpu   = 1'b0;
   endtask

   function automatic bit m_in_acc(input int c);
      return m_busy && (c > m_g) && (c <= m_g + AC);
   endfunction

   task automatic arbitrate();
      if (m_busy && (cyc < m_g + AC + 2)) return;
      m_busy = 1'b0;
      if (reset) return;
      if (bus.vid_req && (!bus.cpu_req || !RR || !m_ptr_cpu)) begin
         m_busy = 1'b1; m_g = cyc; m_port_cpu = 1'b0; m_we = 1'b0;
         m_addr = bus.vid_addr;
      end else if (bus.cpu_req) begin
         m_busy = 1'b1; m_g = cyc; m_port_cpu = 1'b1; m_we = bus.cpu_we;
         m_addr = bus.cpu_addr; m_wdata = bus.cpu_wdata;
      end
      if (m_busy && (m_g == cyc)) m_last_addr = m_addr;
   endtask

   task automatic model_check();
      bit acc;
      bit ackc;
      bit wr;
      int k;
      acc  = m_in_acc(cyc);
      ackc = m_busy && (cyc == m_g + AC + 1);
      wr   = m_port_cpu && m_we;
      k    = cyc - m_g;
      if (ackc) begin
         if (!m_port_cpu)  m_vid_rd = ref_rd(m_addr);
         else if (!m_we)   m_cpu_rd = ref_rd(m_addr);
         else              ref_mem[m_addr] = m_wdata;
         m_ptr_cpu = !m_port_cpu;
      end
      check("vid_ack",   bus.vid_ack, ackc && !m_port_cpu);
      check("cpu_ack",   bus.cpu_ack, ackc && m_port_cpu);
      check("we_n",      SRAM_WE_n, !(acc && wr && (k >= 2) && (k <= AC - 1)));
      check("addr",      SRAM_ADDR, m_last_addr);
      check("cpu_rdata", bus.cpu_rdata, m_cpu_rd);
      check("vid_rdata", bus.vid_rdata, m_vid_rd);
      if (acc && wr) check("wdata", SRAM_DATA, m_wdata);
   endtask

   task automatic step();
      arbitrate();
      @(posedge clock);
      #1;
      cyc++;
      tb_oe    = tb_force || (m_in_acc(cyc) && !(m_port_cpu && m_we));
      sram_drv = phys_rd(SRAM_ADDR);
      @(negedge clock);
      model_check();
   endtask

   task automatic wait_any(input int budget, output bit got_vid, output bit got_cpu, output int at);
      got_vid = 1'b0;
      got_cpu = 1'b0;
      at      = -1;
      for (int i = 0; i < budget; i++) begin
         step();
         if (bus.vid_ack || bus.cpu_ack) begin
            got_vid = bus.vid_ack;
            got_cpu = bus.cpu_ack;
            at      = cyc;
            if (got_vid) bus.vid_req = 1'b0;
            if (got_cpu) bus.cpu_req = 1'b0;
            return;
         end
      end
      check("ack_seen", 32'(got_vid | got_cpu), 1);
   endtask

   function automatic logic [20:0] rand_addr();
      logic [20:0] a;
      a = 21'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) a = a | 21'h1FFFF0;
      return a;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      bit gv;
      bit gc;
      int at;
      int c0;
      int prev;

      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.vid_req = 1'b0; bus.vid_addr = '0;
      model_reset();
      repeat (2) step();
      check("rst_we_n",  SRAM_WE_n, 1);
      check("rst_addr",  SRAM_ADDR, 0);
      check("rst_ack",   {bus.cpu_ack, bus.vid_ack}, 0);
      reset = 1'b0;
      step();

      // CPU write
      bus.cpu_we = 1'b1; bus.cpu_addr = 21'h1ABCD; bus.cpu_wdata = 8'h5A; bus.cpu_req = 1'b1;
      c0 = cyc;
      wait_any(20, gv, gc, at);
      check("t1_port", gc, 1);
      check("t1_lat", at - c0, AC + 1);
      check("t1_mem", phys_rd(21'h1ABCD), 8'h5A);
      step();

      // CPU read of a known location
      phys[21'h00400] = 8'hC3; ref_mem[21'h00400] = 8'hC3;
      bus.cpu_we = 1'b0; bus.cpu_addr = 21'h00400; bus.cpu_req = 1'b1;
      c0 = cyc;
      wait_any(20, gv, gc, at);
      check("t2_lat", at - c0, AC + 1);
      check("t2_cpu_rdata", bus.cpu_rdata, 8'hC3);
      check("t2_vid_rdata", bus.vid_rdata, 8'h00);
      step();

      // Simultaneous requests; pointer favours video here in either policy
      bus.vid_addr = 21'h00010; bus.vid_req = 1'b1;
      bus.cpu_addr = 21'h00020; bus.cpu_we = 1'b0; bus.cpu_req = 1'b1;
      c0 = cyc;
      wait_any(20, gv, gc, at);
      check("t3_first_vid", gv, 1);
      check("t3_vid_lat", at - c0, AC + 1);
      wait_any(20, gv, gc, at);
      check("t3_second_cpu", gc, 1);
      check("t3_cpu_lat", at - c0, 2 * AC + 3);
      step();

      // Video access first, then a tie
      bus.vid_addr = 21'h00030; bus.vid_req = 1'b1;
      wait_any(20, gv, gc, at);
      step();
      bus.vid_addr = 21'h00031; bus.vid_req = 1'b1;
      bus.cpu_addr = 21'h00032; bus.cpu_we = 1'b1; bus.cpu_wdata = 8'h96; bus.cpu_req = 1'b1;
      c0 = cyc;
      wait_any(20, gv, gc, at);
      check("t4_first_cpu", gc, RR);
      check("t4_first_lat", at - c0, AC + 1);
      wait_any(20, gv, gc, at);
      check("t4_second_cpu", gc, !RR);
      check("t4_second_lat", at - c0, 2 * AC + 3);
      step();

      // Reset in the strobe cycle of a CPU write
      bus.cpu_we = 1'b1; bus.cpu_addr = 21'h00055; bus.cpu_wdata = 8'h5A; bus.cpu_req = 1'b1;
      step();
      step();
      check("t5_we_low", SRAM_WE_n, 0);
      reset = 1'b1;
      bus.cpu_req = 1'b0;
      #1;
      check("t5_we_n", SRAM_WE_n, 1);
      check("t5_ack", bus.cpu_ack, 0);
      tb_force = 1'b1; sram_drv = 8'hE7; tb_oe = 1'b1;
      #1;
      check("t5_data_released", SRAM_DATA, 8'hE7);
      tb_force = 1'b0; tb_oe = 1'b0;
      model_reset();
      repeat (2) step();
      reset = 1'b0;
      step();
      bus.cpu_we = 1'b0; bus.cpu_addr = 21'h00400; bus.cpu_req = 1'b1;
      c0 = cyc;
      wait_any(20, gv, gc, at);
      check("t5_after_lat", at - c0, AC + 1);
      check("t5_after_rdata", bus.cpu_rdata, 8'hC3);
      step();

      // Back-to-back video reads with req held
      bus.vid_addr = 21'h0; bus.vid_req = 1'b1;
      c0 = cyc; prev = c0;
      for (int i = 0; i < 3; i++) begin
         wait_any(20, gv, gc, at);
         check("t6_vid", gv, 1);
         check("t6_spacing", at - prev, (i == 0) ? AC + 1 : AC + 2);
         check("t6_data", bus.vid_rdata, ref_rd(21'(i)));
         prev = at;
         if (i < 2) begin
            bus.vid_req  = 1'b1;
            bus.vid_addr = 21'(i + 1);
         end
      end
      step();

      // Random requesters
      for (int i = 0; i < 1500; i++) begin
         step();
         if (bus.vid_ack) begin
            bus.vid_req  = 1'($urandom_range(0, 1));
            bus.vid_addr = rand_addr();
         end else if (!bus.vid_req && ($urandom_range(0, 3) == 0)) begin
            bus.vid_req  = 1'b1;
            bus.vid_addr = rand_addr();
         end
         if (bus.cpu_ack) begin
            bus.cpu_req   = 1'($urandom_range(0, 1));
            bus.cpu_we    = 1'($urandom_range(0, 1));
            bus.cpu_addr  = rand_addr();
            bus.cpu_wdata = 8'($urandom);
         end else if (!bus.cpu_req && ($urandom_range(0, 2) == 0)) begin
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = 1'($urandom_range(0, 1));
            bus.cpu_addr  = rand_addr();
            bus.cpu_wdata = 8'($urandom);
         end
      end
      bus.vid_req = 1'b0;
      bus.cpu_req = 1'b0;
      repeat (AC + 4) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
